// File: rtl/mem_bist32_pkg.sv
// rtl/mem_bist32_pkg.sv - shared types, constants and pattern helper for mem_bist32
package mem_bist32_pkg;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_WR0  = 3'd1,
        S_RD0  = 3'd2,
        S_DRN0 = 3'd3,
        S_WR1  = 3'd4,
        S_RD1  = 3'd5,
        S_DRN1 = 3'd6,
        S_DONE = 3'd7
    } state_t;

    localparam logic [3:0] BMSK_ALL = 4'b1111;

    // Address-derived pattern: upper half is the complement of the lower half,
    // so every bit of the word toggles between the two passes.
    function automatic logic [31:0] pat(input logic [15:0] a16, input logic inv);
        logic [31:0] p;
        p = {~a16, a16};
        return inv ? ~p : p;
    endfunction

endpackage

// File: rtl/mem_bist32_chk.sv
// rtl/mem_bist32_chk.sv - read-compare pipeline, saturating error counter, first-fail capture
module mem_bist32_chk #(
    parameter int ASZ = 15,
    parameter int DSZ = 32,
    parameter int ECW = 16
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           clr,
    input  logic           valid,
    input  logic [ASZ-1:0] addr,
    input  logic [DSZ-1:0] exp,
    input  logic [DSZ-1:0] vo,
    output logic [ECW-1:0] err_cnt,
    output logic           fail,
    output logic [ASZ-1:0] fail_addr,
    output logic [DSZ-1:0] fail_exp,
    output logic [DSZ-1:0] fail_got
);

    localparam logic [ECW-1:0] ERR_MAX = '1;

    logic           v_q;
    logic [ASZ-1:0] a_q;
    logic [DSZ-1:0] e_q;
    logic           mismatch;

    // Read data arrives one cycle after the address, so compare against the registered expectation.
    assign mismatch = v_q && (vo != e_q);

    // Pipeline stage plus error bookkeeping; only the first mismatch of a run is captured.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v_q       <= 1'b0;
            a_q       <= '0;
            e_q       <= '0;
            err_cnt   <= '0;
            fail      <= 1'b0;
            fail_addr <= '0;
            fail_exp  <= '0;
            fail_got  <= '0;
        end else if (clr) begin
            v_q       <= 1'b0;
            err_cnt   <= '0;
            fail      <= 1'b0;
            fail_addr <= '0;
            fail_exp  <= '0;
            fail_got  <= '0;
        end else begin
            v_q <= valid;
            a_q <= addr;
            e_q <= exp;
            if (mismatch) begin
                if (err_cnt != ERR_MAX) begin
                    err_cnt <= err_cnt + 1'b1;
                end
                if (!fail) begin
                    fail      <= 1'b1;
                    fail_addr <= a_q;
                    fail_exp  <= e_q;
                    fail_got  <= vo;
                end
            end
        end
    end

endmodule

// File: rtl/mem_bist32.sv
// rtl/mem_bist32.sv - iBus32 memory self-test initiator: FSM, address counter, bus drive
module mem_bist32
    import mem_bist32_pkg::*;
#(
    parameter int ASZ = 15,
    parameter int DSZ = 32,
    parameter int ECW = 16
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           start,
    input  logic           abort,
    input  logic [ASZ-1:0] addr_lo,
    input  logic [ASZ-1:0] addr_hi,
    output logic [ASZ-1:0] ai,
    output logic           we,
    output logic [DSZ-1:0] vi,
    output logic [3:0]     bmsk,
    input  logic [DSZ-1:0] vo,
    output logic           busy,
    output logic           done,
    output logic           fail,
    output logic [ECW-1:0] err_cnt,
    output logic [ASZ-1:0] fail_addr,
    output logic [DSZ-1:0] fail_exp,
    output logic [DSZ-1:0] fail_got
);

    state_t         state;
    state_t         state_nx;
    logic [ASZ-1:0] lo_q;
    logic [ASZ-1:0] hi_q;
    logic           accept;
    logic           range_ok;
    logic           at_hi;
    logic           rd_valid;
    logic [DSZ-1:0] rd_exp;

    assign accept   = (state == S_IDLE) && start && !abort;
    assign range_ok = (addr_lo <= addr_hi);
    // Equality, not carry, ends each sweep so addr_hi at the top of memory never wraps.
    assign at_hi    = (ai == hi_q);
    assign rd_valid = ((state == S_RD0) || (state == S_RD1)) && !abort;
    assign rd_exp   = DSZ'(pat(16'(ai), state == S_RD1));
    assign bmsk     = BMSK_ALL;

    // State register; reset forces IDLE immediately so we drops without a clock.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state: write sweep, read sweep, one drain cycle, per pass; abort returns to IDLE.
    always_comb begin
        state_nx = state;
        if (state == S_IDLE) begin
            if (accept) begin
                state_nx = range_ok ? S_WR0 : S_DONE;
            end
        end else if (abort) begin
            state_nx = S_IDLE;
        end else begin
            case (state)
                S_WR0:   if (at_hi) state_nx = S_RD0;
                S_RD0:   if (at_hi) state_nx = S_DRN0;
                S_DRN0:  state_nx = S_WR1;
                S_WR1:   if (at_hi) state_nx = S_RD1;
                S_RD1:   if (at_hi) state_nx = S_DRN1;
                S_DRN1:  state_nx = S_DONE;
                S_DONE:  state_nx = S_IDLE;
                default: state_nx = S_IDLE;
            endcase
        end
    end

    // Bus and status outputs decoded from state.
    always_comb begin
        we   = (state == S_WR0) || (state == S_WR1);
        vi   = '0;
        if (we) begin
            vi = DSZ'(pat(16'(ai), state == S_WR1));
        end
        busy = (state != S_IDLE) && (state != S_DONE);
        done = (state == S_DONE);
    end

    // Range latch and address counter; address holds at addr_hi through the drain cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ai   <= '0;
            lo_q <= '0;
            hi_q <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        lo_q <= addr_lo;
                        hi_q <= addr_hi;
                        if (range_ok) begin
                            ai <= addr_lo;
                        end
                    end
                end
                S_WR0, S_WR1: begin
                    if (!abort) begin
                        ai <= at_hi ? lo_q : ai + 1'b1;
                    end
                end
                S_RD0, S_RD1: begin
                    if (!abort && !at_hi) begin
                        ai <= ai + 1'b1;
                    end
                end
                S_DRN0: begin
                    if (!abort) begin
                        ai <= lo_q;
                    end
                end
                default: ;
            endcase
        end
    end

    mem_bist32_chk #(
        .ASZ (ASZ),
        .DSZ (DSZ),
        .ECW (ECW)
    ) u_chk (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr       (accept),
        .valid     (rd_valid),
        .addr      (ai),
        .exp       (rd_exp),
        .vo        (vo),
        .err_cnt   (err_cnt),
        .fail      (fail),
        .fail_addr (fail_addr),
        .fail_exp  (fail_exp),
        .fail_got  (fail_got)
    );

endmodule

// File: tb/tb_mem_bist32.sv
// tb/tb_mem_bist32.sv - self-checking bench for mem_bist32 with a behavioural iBus32 memory
module tb_mem_bist32;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        abort;
    logic [14:0] addr_lo;
    logic [14:0] addr_hi;
    logic [14:0] ai;
    logic        we;
    logic [31:0] vi;
    logic [3:0]  bmsk;
    logic [31:0] vo;
    logic        busy;
    logic        done;
    logic        fail;
    logic [15:0] err_cnt;
    logic [14:0] fail_addr;
    logic [31:0] fail_exp;
    logic [31:0] fail_got;

    int checks = 0;
    int errors = 0;

    logic [31:0] mem [0:32767];
    logic [7:0]  stuck_map;
    logic [46:0] wq[$];
    logic        ai_watch;
    int          ai_bad;

    mem_bist32 dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .abort     (abort),
        .addr_lo   (addr_lo),
        .addr_hi   (addr_hi),
        .ai        (ai),
        .we        (we),
        .vi        (vi),
        .bmsk      (bmsk),
        .vo        (vo),
        .busy      (busy),
        .done      (done),
        .fail      (fail),
        .err_cnt   (err_cnt),
        .fail_addr (fail_addr),
        .fail_exp  (fail_exp),
        .fail_got  (fail_got)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single-port memory: registered read, optional bit-0 stuck-at-1 on low addresses.
    always @(posedge clk) begin
        if (we) mem[ai] <= vi;
        vo <= mem[ai] | (((ai < 15'd8) && stuck_map[ai[2:0]]) ? 32'h1 : 32'h0);
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Write-trace scoreboard: every bus write must match the next expected {addr, data}.
    always @(negedge clk) begin
        if (rst_n && we) begin
            if (wq.size() == 0) begin
                check("wr_unexpected", {49'b0, ai}, 64'h0);
            end else begin
                logic [46:0] e;
                e = wq.pop_front();
                check("wr_trace", {17'b0, ai, vi}, {17'b0, e});
            end
        end
        if (ai_watch && busy && ai != 15'h7fff) ai_bad++;
    end

    task automatic push_writes(input logic [14:0] lo, input logic [14:0] hi, input int passes);
        for (int p = 0; p < passes; p++) begin
            for (int a = int'(lo); a <= int'(hi); a++) begin
                logic [15:0] a16;
                logic [31:0] d;
                a16 = 16'(a);
                d   = {~a16, a16};
                if (p == 1) d = ~d;
                wq.push_back({15'(a), d});
            end
        end
    endtask

    task automatic run_test(input string tag, input logic [14:0] lo, input logic [14:0] hi,
                            input logic [7:0] smap, input int restart_at,
                            input int exp_edge, input int exp_busy,
                            input logic exp_fail, input logic [15:0] exp_err,
                            input logic [14:0] exp_fa, input logic [31:0] exp_fe,
                            input logic [31:0] exp_fg);
        int ecnt;
        int got_edge;
        int bcnt;
        stuck_map = smap;
        wq.delete();
        push_writes(lo, hi, 2);
        @(negedge clk);
        addr_lo = lo;
        addr_hi = hi;
        start   = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        ecnt = 0;
        got_edge = -1;
        bcnt = 0;
        while (ecnt < 2000) begin
            @(negedge clk);
            if (busy) bcnt++;
            if (done) begin
                got_edge = ecnt;
                break;
            end
            if (ecnt == restart_at) start = 1'b1;
            @(posedge clk);
            #1 start = 1'b0;
            ecnt++;
        end
        check({tag, "_done_edge"}, 64'(got_edge), 64'(exp_edge));
        check({tag, "_busy_cycles"}, 64'(bcnt), 64'(exp_busy));
        check({tag, "_fail"}, {63'b0, fail}, {63'b0, exp_fail});
        check({tag, "_err_cnt"}, {48'b0, err_cnt}, {48'b0, exp_err});
        if (exp_fail) begin
            check({tag, "_fail_addr"}, {49'b0, fail_addr}, {49'b0, exp_fa});
            check({tag, "_fail_exp"}, {32'b0, fail_exp}, {32'b0, exp_fe});
            check({tag, "_fail_got"}, {32'b0, fail_got}, {32'b0, exp_fg});
        end
        check({tag, "_writes_left"}, 64'(wq.size()), 64'h0);
        @(posedge clk);
        #1;
        @(negedge clk);
        check({tag, "_done_pulse_end"}, {63'b0, done}, 64'h0);
        check({tag, "_busy_end"}, {63'b0, busy}, 64'h0);
        stuck_map = 8'h00;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int dseen;
        rst_n = 1'b0;
        start = 1'b0;
        abort = 1'b0;
        addr_lo = '0;
        addr_hi = '0;
        stuck_map = 8'h00;
        ai_watch = 1'b0;
        ai_bad = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_we", {63'b0, we}, 64'h0);
        check("rst_busy", {63'b0, busy}, 64'h0);
        check("rst_done", {63'b0, done}, 64'h0);
        check("rst_fail", {63'b0, fail}, 64'h0);
        check("rst_err", {48'b0, err_cnt}, 64'h0);
        check("rst_ai", {49'b0, ai}, 64'h0);
        check("rst_vi", {32'b0, vi}, 64'h0);
        check("rst_bmsk", {60'b0, bmsk}, 64'hf);
        check("rst_fcap", {fail_exp, fail_got}, 64'h0);
        rst_n = 1'b1;
        @(posedge clk);

        run_test("clean", 15'd0, 15'd7, 8'h00, 10, 34, 34, 1'b0, 16'd0, '0, '0, '0);
        run_test("stuck5", 15'd0, 15'd7, 8'h20, -1, 34, 34, 1'b1, 16'd1,
                 15'd5, 32'h0005FFFA, 32'h0005FFFB);
        run_test("stuck56", 15'd0, 15'd7, 8'h60, -1, 34, 34, 1'b1, 16'd2,
                 15'd6, 32'hFFF90006, 32'hFFF90007);
        run_test("empty", 15'd9, 15'd3, 8'h00, -1, 0, 0, 1'b0, 16'd0, '0, '0, '0);

        ai_watch = 1'b1;
        run_test("single", 15'h7fff, 15'h7fff, 8'h00, -1, 6, 6, 1'b0, 16'd0, '0, '0, '0);
        ai_watch = 1'b0;
        check("single_ai_range", 64'(ai_bad), 64'h0);

        // Abort in the middle of the first read sweep.
        wq.delete();
        push_writes(15'd0, 15'd15, 1);
        @(negedge clk);
        addr_lo = 15'd0;
        addr_hi = 15'd15;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (20) @(posedge clk);
        @(negedge clk);
        check("abort_busy_before", {63'b0, busy}, 64'h1);
        abort = 1'b1;
        @(posedge clk);
        #1 abort = 1'b0;
        @(negedge clk);
        check("abort_busy", {63'b0, busy}, 64'h0);
        check("abort_we", {63'b0, we}, 64'h0);
        check("abort_writes_left", 64'(wq.size()), 64'h0);
        dseen = 0;
        repeat (8) begin
            @(negedge clk);
            if (done || busy) dseen++;
        end
        check("abort_no_done", 64'(dseen), 64'h0);
        run_test("post_abort", 15'd0, 15'd7, 8'h00, -1, 34, 34, 1'b0, 16'd0, '0, '0, '0);

        // Asynchronous reset between edges during the second write sweep.
        wq.delete();
        push_writes(15'd0, 15'd7, 2);
        @(negedge clk);
        addr_lo = 15'd0;
        addr_hi = 15'd7;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (20) @(posedge clk);
        @(negedge clk);
        check("arst_we_before", {63'b0, we}, 64'h1);
        #2 rst_n = 1'b0;
        #1;
        check("arst_we", {63'b0, we}, 64'h0);
        check("arst_busy", {63'b0, busy}, 64'h0);
        check("arst_done", {63'b0, done}, 64'h0);
        check("arst_ai", {49'b0, ai}, 64'h0);
        check("arst_vi", {32'b0, vi}, 64'h0);
        check("arst_err", {48'b0, err_cnt}, 64'h0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        wq.delete();
        run_test("post_rst", 15'd0, 15'd3, 8'h00, -1, 18, 18, 1'b0, 16'd0, '0, '0, '0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_bist32.md
Name: mem_bist32

Overview:
Hardware bus initiator for the iBus32 single-port memory interface. It sits on the master side of iBus32, in front of a slave such as spram32_32k, and replaces bench-driven stimulus with an on-chip memory self-test.
- Per run, it writes a deterministic address-derived pattern over a programmable range, then reads it back and compares.
- It then repeats with the inverted pattern.
- It reports pass/fail, an error count, and the first failing address and data.

Parameters:
ASZ, 15, address width of the memory (32K words)
DSZ, 32, data width; fixed at 32 because the pattern is built from two 16-bit halves
ECW, 16, width of the error counter

Ports:
clk      input   1     system clock, shared with iBus32
rst_n    input   1     asynchronous active-low reset
start    input   1     one-cycle pulse; begins a run when idle
abort    input   1     ends the run, returns to IDLE, no done pulse
addr_lo  input   ASZ   first address of the test range
addr_hi  input   ASZ   last address of the test range (inclusive)
ai       output  ASZ   iBus32 address
we       output  1     iBus32 write enable
vi       output  DSZ   iBus32 write data
bmsk     output  4     iBus32 byte mask
vo       input   DSZ   iBus32 read data; valid one cycle after a read address is presented
busy     output  1     high from the start-sampling edge until DONE
done     output  1     one-cycle pulse at end of run
fail     output  1     sticky; set on any mismatch, cleared by the next accepted start
err_cnt  output  ECW   saturating mismatch count for the run
fail_addr output ASZ   address of the first mismatch
fail_exp output  DSZ   expected data at the first mismatch
fail_got output  DSZ   read data at the first mismatch

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE; ai=0, we=0, vi=0, bmsk=4'b1111.
  - busy=0, done=0, fail=0, err_cnt=0, fail_addr=0, fail_exp=0, fail_got=0.
  - Asserting reset mid-run drops we immediately, without waiting for a clock edge.
- Pattern: a16 = addr zero-extended to 16 bits.
  - P0(a) = {~a16, a16}; P1(a) = ~P0(a).
  - Example: P0(5) = 0xFFFA0005, P1(5) = 0x0005FFFA.
- bmsk is always 4'b1111. Let N = addr_hi - addr_lo + 1. addr_lo/addr_hi are latched at start.
- FSM states: IDLE, WR0, RD0, DRN0, WR1, RD1, DRN1, DONE.
  - IDLE: start=1 and addr_lo<=addr_hi -> WR0, with ai=addr_lo, busy=1; fail, err_cnt and capture registers clear.
  - IDLE: start=1 and addr_lo>addr_hi -> DONE directly; no bus activity; fail=0.
  - WRk: we=1, vi=Pk(ai). ai increments each cycle; on the cycle ai==addr_hi, next state is RDk with ai=addr_lo.
  - RDk: we=0. ai increments each cycle. A 1-cycle compare pipeline registers {addr, Pk(addr), valid}, and vo is compared the following cycle. On ai==addr_hi, next state is DRNk.
  - DRNk: we=0, ai holds. Last compare occurs. DRN0 -> WR1 (ai=addr_lo); DRN1 -> DONE.
  - DONE: done=1 for one cycle, busy=0, then IDLE.
- Timing: with start sampled at edge 0, DONE is entered at edge 4N+2.
- start is ignored while busy.
- Mismatch handling:
  - err_cnt increments and saturates at 2^ECW-1.
  - First mismatch of the run loads fail_addr/fail_exp/fail_got; later mismatches never overwrite them.
  - fail is set in the same cycle as the first err_cnt increment.
- abort (any non-IDLE state):
  - Next edge goes to IDLE with we=0, busy=0, and no done.
  - The compare pipeline's valid is squashed.
  - err_cnt and fail keep their values.
- abort and start in the same IDLE cycle: abort wins, start is ignored.
- Wrap-around: addr_hi=2^ASZ-1 must not overflow ai past the range; termination uses the equality compare, not a carry.

Decomposition:
- mem_bist32_pkg holds:
  - the state enum type (typedef enum logic [2:0]);
  - the pattern function pat(addr, inv);
  - the BMSK_ALL constant.
- Sub-module mem_bist32_chk holds the compare pipeline, error counter and first-fail capture. Its inputs are valid, addr, exp, vo and clr.
- mem_bist32 holds the FSM, address counter and bus drive.

Test Plan:
- Clean range, with spram32_32k slave, addr_lo=0, addr_hi=7:
  - busy=1 for 34 cycles; done pulse at edge 34; fail=0, err_cnt=0.
  - Bus trace shows 8 writes of P0, 8 reads, 1 drain, then the same sequence with P1.
- Stuck bit, with the slave model forcing vo[0]=1 at address 5, range 0..7: done; fail=1; err_cnt=1 (P0(5) already has bit0=1, P1(5)=0x0005FFFA also has bit0=0 -> mismatch, so err_cnt=1 from pass 1); fail_addr=5, fail_exp=0x0005FFFA, fail_got=0x0005FFFB.
- Single word, addr_lo=addr_hi=0x7FFF:
  - Writes to 0x7FFF use 0xFFFF80007FFF truncated to {0x8000,0x7FFF} = 0x80007FFF, then the inverse.
  - done at edge 6; ai never leaves 0x7FFF.
- Empty range, addr_lo=9, addr_hi=3: done one cycle after start, we never asserted, fail=0.
- abort during RD0 at range 0..15, cycle 20: we=0 and busy=0 after the next edge; no done pulse; a subsequent start runs normally to done.
- Async reset mid-WR1: deassert rst_n between edges -> we=0 and all outputs at reset values before the next edge. start pulses while busy produce no state restart.
